// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline sequencing controller
//
// Holds the controller state encoding, the writeback-select code that marks
// a load (shared with the decoder), and the width of the event counters.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] WB_MEM = 2'b01;

  localparam int CNT_W = 32;

endpackage

// File: rtl/pipe_ctrl_load_use_det.sv
// rtl/pipe_ctrl_load_use_det.sv - combinational load-use hazard comparator
//
// Ports:
//   i_rs1_addr_id, i_rs2_addr_id  source registers of the instruction in ID
//   i_rs1_used_id, i_rs2_used_id  ID instruction actually reads rs1 / rs2
//   i_rd_addr_ex                  destination register of the instruction in EX
//   i_rd_wren_ex                  EX instruction writes rd
//   i_wb_sel_ex                   EX writeback select (WB_MEM = load)
//   o_hit                         ID consumes the result of the load in EX
module load_use_det
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_rs1_addr_id,
  input  logic [4:0] i_rs2_addr_id,
  input  logic       i_rs1_used_id,
  input  logic       i_rs2_used_id,
  input  logic [4:0] i_rd_addr_ex,
  input  logic       i_rd_wren_ex,
  input  logic [1:0] i_wb_sel_ex,
  output logic       o_hit
);

  logic w_load_ex;
  logic w_rs1_match;
  logic w_rs2_match;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign w_load_ex   = (i_wb_sel_ex == WB_MEM) && i_rd_wren_ex && (i_rd_addr_ex != 5'd0);
  assign w_rs1_match = i_rs1_used_id && (i_rs1_addr_id == i_rd_addr_ex);
  assign w_rs2_match = i_rs2_used_id && (i_rs2_addr_id == i_rd_addr_ex);
  assign o_hit       = w_load_ex && (w_rs1_match || w_rs2_match);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - 5-stage pipeline sequencing controller (freeze, flush, load-use, init)
//
// Parameters:
//   MEM_TIMEOUT  max frozen cycles for one memory access before forced release (>=2)
//   INIT_CYCLES  cycles IF/ID and ID/EX flushes are held after reset release (>=1)
// Ports:
//   i_clk, i_reset                 clock, asynchronous active-low reset
//   i_rs1/rs2_addr_id, *_used_id   ID source operands
//   i_rd_addr_ex, i_rd_wren_ex     EX destination
//   i_wb_sel_ex                    EX writeback select
//   i_pc_sel_ex                    taken branch/jump resolved in EX
//   i_mem_req, i_mem_ack           MEM stage access outstanding / completing
//   o_enable_pc/if/id/ex/mem       register enables
//   o_reset_if, o_reset_id         active-low sync flush of IF/ID and ID/EX
//   o_mem_err                      one-cycle pulse on memory timeout
//   o_stall_cnt, o_flush_cnt       event counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int INIT_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_rs1_addr_id,
  input  logic [4:0]       i_rs2_addr_id,
  input  logic             i_rs1_used_id,
  input  logic             i_rs2_used_id,
  input  logic [4:0]       i_rd_addr_ex,
  input  logic             i_rd_wren_ex,
  input  logic [1:0]       i_wb_sel_ex,
  input  logic             i_pc_sel_ex,
  input  logic             i_mem_req,
  input  logic             i_mem_ack,
  output logic             o_enable_pc,
  output logic             o_enable_if,
  output logic             o_enable_id,
  output logic             o_enable_ex,
  output logic             o_enable_mem,
  output logic             o_reset_if,
  output logic             o_reset_id,
  output logic             o_mem_err,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam int INIT_W = $clog2(INIT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

  state_t            r_state;
  logic [INIT_W-1:0] r_init_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_hit;
  logic w_in_pipe;
  logic w_pending;
  logic w_timeout;
  logic w_frozen;
  logic w_flush;
  logic w_stall;

  load_use_det u_load_use_det (
    .i_rs1_addr_id (i_rs1_addr_id),
    .i_rs2_addr_id (i_rs2_addr_id),
    .i_rs1_used_id (i_rs1_used_id),
    .i_rs2_used_id (i_rs2_used_id),
    .i_rd_addr_ex  (i_rd_addr_ex),
    .i_rd_wren_ex  (i_rd_wren_ex),
    .i_wb_sel_ex   (i_wb_sel_ex),
    .o_hit         (w_hit)
  );

  // Hazard resolution, priority freeze > flush > load-use. A timeout is a
  // forced release, so it drops out of the freeze term and behaves like ack.
  assign w_in_pipe = (r_state != INIT);
  assign w_pending = i_mem_req && !i_mem_ack;
  assign w_timeout = (r_state == MEM_WAIT) && w_pending && (r_wait_cnt == WAIT_MAX);
  assign w_frozen  = w_in_pipe && w_pending && !w_timeout;
  assign w_flush   = w_in_pipe && !w_frozen && i_pc_sel_ex;
  assign w_stall   = w_in_pipe && !w_frozen && !i_pc_sel_ex && w_hit;

  // Outputs are gated directly by the reset pin so they drop the moment reset
  // is asserted, even between clock edges.
  always_comb begin
    o_enable_pc  = 1'b0;
    o_enable_if  = 1'b0;
    o_enable_id  = 1'b0;
    o_enable_ex  = 1'b0;
    o_enable_mem = 1'b0;
    o_reset_if   = 1'b0;
    o_reset_id   = 1'b0;
    o_mem_err    = 1'b0;
    if (i_reset) begin
      if (!w_in_pipe) begin
        o_enable_pc  = 1'b1;
        o_enable_if  = 1'b1;
        o_enable_id  = 1'b1;
        o_enable_ex  = 1'b1;
        o_enable_mem = 1'b1;
      end else begin
        // ID/EX stays enabled on a load-use stall so its flush inserts the bubble
        o_enable_pc  = !w_frozen && !w_stall;
        o_enable_if  = !w_frozen && !w_stall;
        o_enable_id  = !w_frozen;
        o_enable_ex  = !w_frozen;
        o_enable_mem = !w_frozen;
        o_reset_if   = !w_flush;
        o_reset_id   = !(w_flush || w_stall);
        o_mem_err    = w_timeout;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= INIT;
      r_init_cnt  <= '0;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        INIT: begin
          r_init_cnt <= r_init_cnt + 1'b1;
          if (r_init_cnt == INIT_LAST) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_frozen) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          // Ack, timeout or a dropped request all release the freeze
          if (w_frozen) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end else begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
          end
        end
        default: begin
          r_state <= INIT;
        end
      endcase
      if (w_frozen || w_stall) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_flush) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl with a behavioural reference model
module tb_pipe_ctrl;

  localparam int TMO  = 4;
  localparam int INIT = 2;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       wren;
    logic [1:0] wb;
    logic       pc_sel;
    logic       req;
    logic       ack;
  } stim_t;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [4:0]  i_rs1_addr_id = '0;
  logic [4:0]  i_rs2_addr_id = '0;
  logic        i_rs1_used_id = 1'b0;
  logic        i_rs2_used_id = 1'b0;
  logic [4:0]  i_rd_addr_ex = '0;
  logic        i_rd_wren_ex = 1'b0;
  logic [1:0]  i_wb_sel_ex = '0;
  logic        i_pc_sel_ex = 1'b0;
  logic        i_mem_req = 1'b0;
  logic        i_mem_ack = 1'b0;
  logic        o_enable_pc, o_enable_if, o_enable_id, o_enable_ex, o_enable_mem;
  logic        o_reset_if, o_reset_id, o_mem_err;
  logic [31:0] o_stall_cnt, o_flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: cycles of init left, frozen cycles spent on the
  // current memory access, and the two event counts.
  int          m_init_left = INIT;
  int          m_frozen = 0;
  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;

  pipe_ctrl #(.MEM_TIMEOUT(TMO), .INIT_CYCLES(INIT)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_rs1_addr_id (i_rs1_addr_id),
    .i_rs2_addr_id (i_rs2_addr_id),
    .i_rs1_used_id (i_rs1_used_id),
    .i_rs2_used_id (i_rs2_used_id),
    .i_rd_addr_ex  (i_rd_addr_ex),
    .i_rd_wren_ex  (i_rd_wren_ex),
    .i_wb_sel_ex   (i_wb_sel_ex),
    .i_pc_sel_ex   (i_pc_sel_ex),
    .i_mem_req     (i_mem_req),
    .i_mem_ack     (i_mem_ack),
    .o_enable_pc   (o_enable_pc),
    .o_enable_if   (o_enable_if),
    .o_enable_id   (o_enable_id),
    .o_enable_ex   (o_enable_ex),
    .o_enable_mem  (o_enable_mem),
    .o_reset_if    (o_reset_if),
    .o_reset_id    (o_reset_id),
    .o_mem_err     (o_mem_err),
    .o_stall_cnt   (o_stall_cnt),
    .o_flush_cnt   (o_flush_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 2))
      0:       return 5'd0;
      1:       return 5'd1;
      default: return 5'd5;
    endcase
  endfunction

  // One clock cycle: drive after the edge, predict, check at the falling edge,
  // then advance the model to what the next edge should produce.
  task automatic step(input stim_t s);
    logic [7:0] e;
    logic       hit, pend, tmo, frz;
    int         inc_s, inc_f;
    @(posedge i_clk);
    #1;
    i_reset       = s.rst;
    i_rs1_addr_id = s.rs1;
    i_rs2_addr_id = s.rs2;
    i_rs1_used_id = s.u1;
    i_rs2_used_id = s.u2;
    i_rd_addr_ex  = s.rd;
    i_rd_wren_ex  = s.wren;
    i_wb_sel_ex   = s.wb;
    i_pc_sel_ex   = s.pc_sel;
    i_mem_req     = s.req;
    i_mem_ack     = s.ack;
    inc_s = 0;
    inc_f = 0;
    hit = (s.wb == 2'b01) && s.wren && (s.rd != 5'd0) &&
          ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    if (!s.rst) begin
      e = 8'b00000_00_0;
      m_stall = '0;
      m_flush = '0;
      m_init_left = INIT;
      m_frozen = 0;
    end else if (m_init_left > 0) begin
      e = 8'b11111_00_0;
      m_init_left--;
    end else begin
      pend = s.req && !s.ack;
      tmo  = pend && (m_frozen == TMO);
      frz  = pend && (m_frozen < TMO);
      if (frz) begin
        e = 8'b00000_11_0;
        inc_s = 1;
        m_frozen++;
      end else begin
        m_frozen = 0;
        if (s.pc_sel) begin
          e = {5'b11111, 2'b00, tmo};
          inc_f = 1;
        end else if (hit) begin
          e = {5'b00111, 2'b10, tmo};
          inc_s = 1;
        end else begin
          e = {5'b11111, 2'b11, tmo};
        end
      end
    end
    @(negedge i_clk);
    check("ctl", {24'd0, o_enable_pc, o_enable_if, o_enable_id, o_enable_ex, o_enable_mem,
                  o_reset_if, o_reset_id, o_mem_err}, {24'd0, e});
    check("stall_cnt", o_stall_cnt, m_stall);
    check("flush_cnt", o_flush_cnt, m_flush);
    m_stall = m_stall + 32'(inc_s);
    m_flush = m_flush + 32'(inc_f);
  endtask

  initial begin
    stim_t s;
    int    lvl;

    // Reset and init sequence
    step('0);
    step('0);
    step(idle());
    step(idle());
    step(idle());
    check("init_stall", o_stall_cnt, 32'd0);
    check("init_flush", o_flush_cnt, 32'd0);

    // Load-use: lw x5 in EX, add x6,x5,x1 in ID
    s = idle();
    s.rd = 5'd5; s.wren = 1'b1; s.wb = 2'b01;
    s.rs1 = 5'd5; s.rs2 = 5'd1; s.u1 = 1'b1; s.u2 = 1'b1;
    step(s);
    check("lu_pc", {31'd0, o_enable_pc}, 32'd0);
    step(idle());
    check("lu_cnt", o_stall_cnt, 32'd1);
    // Load into x0 is not a hazard
    s.rd = 5'd0; s.rs1 = 5'd0;
    step(s);
    check("lu_x0", {31'd0, o_enable_pc}, 32'd1);

    // Taken branch, then branch coinciding with load-use
    s = idle();
    s.pc_sel = 1'b1;
    step(s);
    s.rd = 5'd5; s.wren = 1'b1; s.wb = 2'b01; s.rs2 = 5'd5; s.u2 = 1'b1;
    step(s);
    step(idle());
    check("br_flush", o_flush_cnt, 32'd2);
    check("br_stall", o_stall_cnt, 32'd1);

    // Memory wait of 3 cycles; branch in EX flushes on the ack cycle
    s = idle();
    s.req = 1'b1;
    repeat (3) step(s);
    s.ack = 1'b1; s.pc_sel = 1'b1;
    step(s);
    check("mw_rel", {30'd0, o_enable_pc, o_reset_if}, 32'd2);
    step(idle());
    check("mw_stall", o_stall_cnt, 32'd4);
    check("mw_flush", o_flush_cnt, 32'd3);

    // Timeout: 4 frozen cycles then a forced release with o_mem_err
    s = idle();
    s.req = 1'b1;
    repeat (TMO) step(s);
    step(s);
    check("tmo_err", {31'd0, o_mem_err}, 32'd1);
    step(idle());

    // Reset asserted between edges while a timeout would be due
    repeat (TMO) step(s);
    s.rst = 1'b0;
    step(s);
    check("rst_err", {31'd0, o_mem_err}, 32'd0);
    step(idle());
    step(idle());
    step(idle());

    // Randomized segments with varying memory-request density
    for (int seg = 0; seg < 20; seg++) begin
      lvl = $urandom_range(0, 3);
      for (int c = 0; c < 60; c++) begin
        s.rst    = ($urandom_range(0, 199) != 0);
        s.rs1    = pick_reg();
        s.rs2    = pick_reg();
        s.u1     = $urandom_range(0, 1) == 1;
        s.u2     = $urandom_range(0, 1) == 1;
        s.rd     = pick_reg();
        s.wren   = $urandom_range(0, 3) != 0;
        s.wb     = 2'($urandom_range(0, 3));
        s.pc_sel = $urandom_range(0, 5) == 0;
        s.req    = $urandom_range(0, 3) < lvl;
        s.ack    = $urandom_range(0, 4) == 0;
        step(s);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
